// File: rtl/rect_drop_sched_pkg.sv
// rtl/rect_drop_sched_pkg.sv - display geometry, motion constants and state encoding for the drop scheduler
package rect_drop_sched_pkg;

   localparam int DISPLAY_WIDTH  = 800;
   localparam int DISPLAY_HEIGHT = 600;
   localparam int WIDTH_RECT     = 48;
   localparam int HEIGHT_RECT    = 64;
   localparam int GRAVITY        = 1;
   localparam int VMAX           = 24;
   localparam int HOLD_FRAMES    = 30;

   typedef enum logic [1:0] {
      FOLLOW = 2'd0,
      FALL   = 2'd1,
      LANDED = 2'd2
   } state_e;

   function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/rect_drop_sched_if.sv
// rtl/rect_drop_sched_if.sv - timing/mouse inputs and rectangle position outputs of the drop scheduler
interface rect_drop_sched_if;

   logic        vblnk;
   logic        mouse_left;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        falling;
   logic        landed;

   modport master (
      output vblnk, mouse_left, mouse_xpos, mouse_ypos,
      input  xpos, ypos, falling, landed
   );

   modport slave (
      input  vblnk, mouse_left, mouse_xpos, mouse_ypos,
      output xpos, ypos, falling, landed
   );

endinterface

// File: rtl/rect_drop_sched_edge_det.sv
// rtl/rect_drop_sched_edge_det.sv - registered rising-edge detector with selectable reset level
module rect_drop_sched_edge_det #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   // Resetting to 1 suppresses an edge for a level already high at reset release.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_q <= RESET_VAL;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/rect_drop_sched.sv
// rtl/rect_drop_sched.sv - frame-synchronous follow/fall/rest scheduler for the on-screen rectangle
module rect_drop_sched
   import rect_drop_sched_pkg::*;
#(
   parameter int P_DISPLAY_WIDTH  = DISPLAY_WIDTH,
   parameter int P_DISPLAY_HEIGHT = DISPLAY_HEIGHT,
   parameter int P_WIDTH_RECT     = WIDTH_RECT,
   parameter int P_HEIGHT_RECT    = HEIGHT_RECT,
   parameter int P_GRAVITY        = GRAVITY,
   parameter int P_VMAX           = VMAX,
   parameter int P_HOLD_FRAMES    = HOLD_FRAMES
) (
   input  logic             pclk,
   input  logic             rst,
   rect_drop_sched_if.slave bus
);

   localparam logic [11:0] XMAX  = 12'(P_DISPLAY_WIDTH - P_WIDTH_RECT - 1);
   localparam logic [11:0] FLOOR = 12'(P_DISPLAY_HEIGHT - P_HEIGHT_RECT - 1);
   localparam int          HW    = $clog2(P_HOLD_FRAMES + 1);

   logic tick;
   logic rise;

   rect_drop_sched_edge_det #(.RESET_VAL(1'b1)) u_vblnk_det (
      .clk_i  (pclk),
      .rst_i  (rst),
      .d_i    (bus.vblnk),
      .rise_o (tick)
   );

   rect_drop_sched_edge_det #(.RESET_VAL(1'b1)) u_left_det (
      .clk_i  (pclk),
      .rst_i  (rst),
      .d_i    (bus.mouse_left),
      .rise_o (rise)
   );

   state_e          state_q;
   logic [11:0]     xpos_q;
   logic [11:0]     ypos_q;
   logic [7:0]      vel_q;
   logic [HW-1:0]   hold_q;
   logic            press_pend_q;
   logic            falling_q;
   logic            landed_q;

   logic [8:0]      vel_inc_d;
   logic [7:0]      vel_n_d;
   logic [12:0]     sum_d;
   logic            press_d;

   // Integrator runs one bit wider so a near-floor step cannot wrap.
   always_comb begin
      vel_inc_d = {1'b0, vel_q} + 9'(P_GRAVITY);
      vel_n_d   = (vel_inc_d > 9'(P_VMAX)) ? 8'(P_VMAX) : vel_inc_d[7:0];
      sum_d     = {1'b0, ypos_q} + {5'd0, vel_n_d};
      press_d   = press_pend_q | rise;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= FOLLOW;
         xpos_q       <= '0;
         ypos_q       <= '0;
         vel_q        <= '0;
         hold_q       <= '0;
         press_pend_q <= 1'b0;
         falling_q    <= 1'b0;
         landed_q     <= 1'b0;
      end else begin
         landed_q <= 1'b0;
         unique case (state_q)
            FOLLOW: begin
               if (tick) begin
                  xpos_q <= clamp12(bus.mouse_xpos, XMAX);
                  ypos_q <= clamp12(bus.mouse_ypos, FLOOR);
                  if (press_d) begin
                     vel_q        <= '0;
                     press_pend_q <= 1'b0;
                     falling_q    <= 1'b1;
                     state_q      <= FALL;
                  end
               end else if (rise) begin
                  press_pend_q <= 1'b1;
               end
            end
            FALL: begin
               press_pend_q <= 1'b0;
               if (tick) begin
                  vel_q <= vel_n_d;
                  if (sum_d >= {1'b0, FLOOR}) begin
                     ypos_q    <= FLOOR;
                     landed_q  <= 1'b1;
                     hold_q    <= '0;
                     falling_q <= 1'b0;
                     state_q   <= LANDED;
                  end else begin
                     ypos_q <= sum_d[11:0];
                  end
               end
            end
            LANDED: begin
               press_pend_q <= 1'b0;
               if (tick) begin
                  if (hold_q == HW'(P_HOLD_FRAMES - 1)) begin
                     state_q <= FOLLOW;
                  end else begin
                     hold_q <= hold_q + 1'b1;
                  end
               end
            end
            default: begin
               press_pend_q <= 1'b0;
               falling_q    <= 1'b0;
               state_q      <= FOLLOW;
            end
         endcase
      end
   end

   assign bus.xpos    = xpos_q;
   assign bus.ypos    = ypos_q;
   assign bus.falling = falling_q;
   assign bus.landed  = landed_q;

endmodule
